// File: rtl/timer_pkg.sv
// Shared types and helpers for the countdown timer controller.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } timer_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Command/status bundle between the timer controller and its user logic.
interface timer_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic             pause;
    logic             clear;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] remaining;
    logic             running;
    logic             paused;
    logic             expired;
    logic             done;
    logic             tick;

    modport master (
        output start, pause, clear, load_val,
        input  remaining, running, paused, expired, done, tick
    );

    modport slave (
        input  start, pause, clear, load_val,
        output remaining, running, paused, expired, done, tick
    );
endinterface

// File: rtl/tick_gen.sv
// Single-clock prescaler: tick is a combinational wrap strobe while enabled.
module tick_gen
    import timer_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic clk_50m,
    input  logic reset_n,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int unsigned     PW   = cnt_width(DIV);
    localparam logic [PW-1:0]   LAST = PW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("tick_gen: DIV must be at least 2");
    end

    logic [PW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (sync_clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer FSM and seconds counter on clk_50m; all outputs registered.
// Optional: define TIMER_CTRL_AUTO_RELOAD_EN for a periodic (auto-reloading) timer.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic   clk_50m,
    input  logic   reset_n,
    timer_ctrl_if.slave bus
);

    localparam int unsigned      DIV = CLK_HZ / TICK_HZ;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    timer_state_e     state, state_d;
    logic [CNT_W-1:0] rem_d;
    logic             done_d, tick_d;
    logic             wrap, start_ok, pre_en, pre_clr;

    assign start_ok = bus.start && (state == IDLE || state == EXPIRED);
    assign pre_en   = (state == RUN);
    assign pre_clr  = bus.clear || start_ok;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk_50m  (clk_50m),
        .reset_n  (reset_n),
        .en       (pre_en),
        .sync_clr (pre_clr),
        .tick     (wrap)
    );

    always_comb begin
        state_d = state;
        rem_d   = bus.remaining;
        done_d  = 1'b0;
        tick_d  = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
            rem_d   = '0;
        end else begin
            case (state)
                IDLE, EXPIRED: begin
                    if (bus.start) begin
                        if (bus.load_val != '0) begin
                            state_d = RUN;
                            rem_d   = bus.load_val;
                        end else begin
                            state_d = EXPIRED;
                            rem_d   = '0;
                            done_d  = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (wrap) begin
                        tick_d = 1'b1;
                        if (bus.remaining > ONE) begin
                            rem_d = bus.remaining - ONE;
                        end else begin
                            done_d = 1'b1;
`ifdef TIMER_CTRL_AUTO_RELOAD_EN
                            if (bus.load_val != '0) begin
                                rem_d = bus.load_val;
                            end else begin
                                rem_d   = '0;
                                state_d = EXPIRED;
                            end
`else
                            rem_d   = '0;
                            state_d = EXPIRED;
`endif
                        end
                    end
                    // Wrap/expiry is resolved first so expiry beats a same-cycle pause.
                    if (state_d == RUN && !bus.start && bus.pause) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (bus.start) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            bus.remaining <= '0;
            bus.running   <= 1'b0;
            bus.paused    <= 1'b0;
            bus.expired   <= 1'b0;
            bus.done      <= 1'b0;
            bus.tick      <= 1'b0;
        end else begin
            state         <= state_d;
            bus.remaining <= rem_d;
            bus.running   <= (state_d == RUN);
            bus.paused    <= (state_d == PAUSE);
            bus.expired   <= (state_d == EXPIRED);
            bus.done      <= done_d;
            bus.tick      <= tick_d;
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl with DIV=10 (CLK_HZ=10, TICK_HZ=1).
module tb_timer_ctrl;

    logic clk_50m = 1'b0;
    logic reset_n = 1'b0;

    timer_ctrl_if #(.CNT_W(8)) bus ();

    timer_ctrl #(
        .CLK_HZ  (10),
        .TICK_HZ (1),
        .CNT_W   (8)
    ) dut (
        .clk_50m (clk_50m),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_50m = ~clk_50m;

    int unsigned   errors = 0;
    int unsigned   checks = 0;
    int unsigned   tick_cnt = 0;
    int unsigned   done_cnt = 0;
    logic [12:0]   exp_q[$];
    logic [12:0]   got, want;

    always @(negedge clk_50m) begin
        if (bus.tick) tick_cnt++;
        if (bus.done) done_cnt++;
    end

    // Packed view: {remaining, running, paused, expired, done, tick}
    function automatic logic [12:0] mk(input int unsigned rem, input bit r, input bit p,
                                       input bit e, input bit d, input bit t);
        return {8'(rem), r, p, e, d, t};
    endfunction

    function automatic logic [12:0] obs();
        return {bus.remaining, bus.running, bus.paused, bus.expired, bus.done, bus.tick};
    endfunction

    task automatic step();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0; bus.load_val = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk_50m);
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        got = obs(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL reset_state got=%h want=%h", got, want); end
        reset_n = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        step();
        got = obs(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL reset_idle got=%h want=%h", got, want); end
    endtask

    task automatic go_idle(input string tag);
        bus.clear = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        step();
        bus.clear = 1'b0;
        got = obs(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL %s_clear got=%h want=%h", tag, got, want); end
    endtask

    task automatic test_countdown();
        int unsigned d0;
        d0 = done_cnt;
        bus.load_val = 8'd3; bus.start = 1'b1;
        exp_q.push_back(mk(3, 1, 0, 0, 0, 0));
        for (int unsigned k = 1; k <= 32; k++) begin
            if (k == 30)      exp_q.push_back(mk(0, 0, 0, 1, 1, 1));
            else if (k > 30)  exp_q.push_back(mk(0, 0, 0, 1, 0, 0));
            else              exp_q.push_back(mk(3 - k / 10, 1, 0, 0, 0, (k % 10) == 0));
        end
        step();
        bus.start = 1'b0;
        for (int unsigned k = 0; k <= 32; k++) begin
            if (k != 0) step();
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL countdown k=%0d got=%h want=%h", k, got, want); end
        end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL countdown_done_pulses got=%0d want=1", done_cnt - d0); end
        // Back-to-back restart straight from EXPIRED
        bus.load_val = 8'd2; bus.start = 1'b1;
        exp_q.push_back(mk(2, 1, 0, 0, 0, 0));
        step();
        bus.start = 1'b0;
        got = obs(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL restart_from_expired got=%h want=%h", got, want); end
    endtask

    task automatic test_pause();
        int unsigned t0;
        go_idle("pause");
        bus.load_val = 8'd3; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (14) step();
        bus.pause = 1'b1;
        exp_q.push_back(mk(2, 0, 1, 0, 0, 0));
        step();
        got = obs(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL pause_enter got=%h want=%h", got, want); end
        t0 = tick_cnt;
        for (int unsigned k = 0; k < 50; k++) exp_q.push_back(mk(2, 0, 1, 0, 0, 0));
        for (int unsigned k = 0; k < 50; k++) begin
            step();
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL pause_hold k=%0d got=%h want=%h", k, got, want); end
        end
        checks++;
        if (tick_cnt !== t0) begin errors++; $display("FAIL pause_no_tick got=%0d want=%0d", tick_cnt, t0); end
        bus.pause = 1'b0; bus.start = 1'b1;
        for (int unsigned k = 0; k < 5; k++) exp_q.push_back(mk(2, 1, 0, 0, 0, 0));
        exp_q.push_back(mk(1, 1, 0, 0, 0, 1));
        step();
        bus.start = 1'b0;
        for (int unsigned k = 0; k <= 5; k++) begin
            if (k != 0) step();
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL resume k=%0d got=%h want=%h", k, got, want); end
        end
    endtask

    task automatic test_zero_load();
        int unsigned t0, d0;
        go_idle("zero");
        t0 = tick_cnt; d0 = done_cnt;
        bus.load_val = 8'd0; bus.start = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 1, 1, 0));
        step();
        bus.start = 1'b0;
        got = obs(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL zero_load_expire got=%h want=%h", got, want); end
        for (int unsigned k = 0; k < 25; k++) exp_q.push_back(mk(0, 0, 0, 1, 0, 0));
        for (int unsigned k = 0; k < 25; k++) begin
            step();
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL zero_load_hold k=%0d got=%h want=%h", k, got, want); end
        end
        checks++;
        if (tick_cnt !== t0 || done_cnt - d0 !== 1) begin
            errors++; $display("FAIL zero_load_pulses ticks=%0d dones=%0d want 0/1", tick_cnt - t0, done_cnt - d0);
        end
    endtask

    task automatic test_clear_on_wrap();
        int unsigned t0, d0;
        go_idle("clrwrap");
        bus.load_val = 8'd1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        t0 = tick_cnt; d0 = done_cnt;
        bus.clear = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        step();
        bus.clear = 1'b0;
        got = obs(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL clear_on_wrap got=%h want=%h", got, want); end
        repeat (12) step();
        checks++;
        if (tick_cnt !== t0 || done_cnt !== d0) begin
            errors++; $display("FAIL clear_on_wrap_pulses ticks=%0d dones=%0d want 0/0", tick_cnt - t0, done_cnt - d0);
        end
        bus.load_val = 8'd4; bus.start = 1'b1; bus.clear = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        step();
        bus.start = 1'b0; bus.clear = 1'b0;
        got = obs(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL start_plus_clear got=%h want=%h", got, want); end
    endtask

    task automatic test_pause_on_final();
        go_idle("pfinal");
        bus.load_val = 8'd1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        bus.pause = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 1, 1, 1));
        exp_q.push_back(mk(0, 0, 0, 1, 0, 0));
        step();
        bus.pause = 1'b0;
        got = obs(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL pause_on_final got=%h want=%h", got, want); end
        step();
        got = obs(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL pause_on_final_hold got=%h want=%h", got, want); end
    endtask

    task automatic test_async_reset();
        int unsigned d0;
        go_idle("areset");
        bus.load_val = 8'd5; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (12) step();
        d0 = done_cnt;
        #3;
        reset_n = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        #1;
        got = obs(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL async_reset_now got=%h want=%h", got, want); end
        repeat (3) step();
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        #2;
        reset_n = 1'b1;
        step();
        got = obs(); want = exp_q.pop_front(); checks++;
        if (got !== want || done_cnt !== d0) begin
            errors++; $display("FAIL async_reset_after got=%h want=%h dones=%0d", got, want, done_cnt - d0);
        end
    endtask

`ifdef TIMER_CTRL_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        int unsigned d0;
        go_idle("reload");
        d0 = done_cnt;
        bus.load_val = 8'd2; bus.start = 1'b1;
        for (int unsigned k = 1; k <= 60; k++) begin
            if (k % 20 == 0)      exp_q.push_back(mk(2, 1, 0, 0, 1, 1));
            else if (k % 10 == 0) exp_q.push_back(mk(1, 1, 0, 0, 0, 1));
            else                  exp_q.push_back(mk((k % 20) < 10 ? 2 : 1, 1, 0, 0, 0, 0));
        end
        step();
        bus.start = 1'b0;
        for (int unsigned k = 1; k <= 60; k++) begin
            step();
            got = obs(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL auto_reload k=%0d got=%h want=%h", k, got, want); end
        end
        checks++;
        if (done_cnt - d0 !== 3) begin errors++; $display("FAIL auto_reload_dones got=%0d want=3", done_cnt - d0); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef TIMER_CTRL_AUTO_RELOAD_EN
        test_auto_reload();
`else
        test_countdown();
        test_pause_on_final();
`endif
        test_pause();
        test_zero_load();
        test_clear_on_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
